// File: rtl/mac_operand_accumulator.sv
// Two-word operand capture from the keypad scanner, 16-cycle shift-add multiply,
// and a running sum of products with sticky overflow / lost-word flags.
module mac_operand_accumulator #(
    parameter int ACC_W = 40
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             data_ready,
    input  logic [15:0]      mem_reg,
    input  logic             acc_clr,
    output logic [15:0]      op_a,
    output logic [15:0]      op_b,
    output logic [31:0]      product,
    output logic [ACC_W-1:0] acc_out,
    output logic             done,
    output logic             busy,
    output logic             overflow,
    output logic             lost_word,
    output logic [1:0]       state
);

    // Handshake: data_ready is a level from the scanner; a word is taken only on its
    // rising edge (data_ready & ~dr_q), so a held-high flag yields one arrival.
    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        MULT  = 2'd2,
        ACC   = 2'd3
    } state_t;

    state_t          cur;
    state_t          nxt;
    logic            dr_q;
    logic            arrival;
    logic [3:0]      step;
    logic [31:0]     partial;
    logic [31:0]     addend;
    logic [ACC_W:0]  sum;

    assign arrival = data_ready & ~dr_q;
    assign state   = cur;
    assign busy    = (cur == MULT) || (cur == ACC);
    assign addend  = op_b[step] ? ({16'b0, op_a} << step) : 32'd0;
    assign sum     = {1'b0, acc_out} + {{(ACC_W - 31){1'b0}}, product};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cur <= GET_A;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        if (acc_clr) begin
            nxt = GET_A;
        end else begin
            case (cur)
                GET_A: if (arrival) nxt = GET_B;
                GET_B: if (arrival) nxt = MULT;
                MULT:  if (step == 4'd15) nxt = ACC;
                ACC:   nxt = GET_A;
                default: nxt = GET_A;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            dr_q      <= 1'b0;
            op_a      <= 16'd0;
            op_b      <= 16'd0;
            product   <= 32'd0;
            acc_out   <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            lost_word <= 1'b0;
            step      <= 4'd0;
            partial   <= 32'd0;
        end else begin
            dr_q <= data_ready;
            done <= 1'b0;
            if (acc_clr) begin
                // Clear wins over any arrival on this edge; operands are kept.
                product   <= 32'd0;
                acc_out   <= '0;
                overflow  <= 1'b0;
                lost_word <= 1'b0;
                step      <= 4'd0;
                partial   <= 32'd0;
            end else begin
                case (cur)
                    GET_A: begin
                        if (arrival) op_a <= mem_reg;
                    end
                    GET_B: begin
                        if (arrival) begin
                            op_b    <= mem_reg;
                            step    <= 4'd0;
                            partial <= 32'd0;
                        end
                    end
                    MULT: begin
                        partial <= partial + addend;
                        step    <= step + 4'd1;
                        if (step == 4'd15) product <= partial + addend;
                        if (arrival) lost_word <= 1'b1;
                    end
                    ACC: begin
                        acc_out <= sum[ACC_W-1:0];
                        if (sum[ACC_W]) overflow <= 1'b1;
                        done <= 1'b1;
                        if (arrival) lost_word <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_operand_accumulator.sv
// Randomised and directed bench for mac_operand_accumulator with a transaction-level
// model; both the default-width and a 32-bit-accumulator instance are checked.
module tb_mac_operand_accumulator;

  logic        clk = 1'b0;
  logic        Reset;
  logic        data_ready;
  logic [15:0] mem_reg;
  logic        acc_clr;

  logic [15:0] op_a, op_b;
  logic [31:0] product;
  logic [39:0] acc_out;
  logic        done, busy, overflow, lost_word;
  logic [1:0]  state;

  logic [15:0] op_a32, op_b32;
  logic [31:0] product32;
  logic [31:0] acc_out32;
  logic        done32, busy32, overflow32, lost_word32;
  logic [1:0]  state32;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  mac_operand_accumulator dut (
    .Clock(clk), .Reset(Reset), .data_ready(data_ready), .mem_reg(mem_reg), .acc_clr(acc_clr),
    .op_a(op_a), .op_b(op_b), .product(product), .acc_out(acc_out), .done(done), .busy(busy),
    .overflow(overflow), .lost_word(lost_word), .state(state)
  );

  mac_operand_accumulator #(.ACC_W(32)) dut32 (
    .Clock(clk), .Reset(Reset), .data_ready(data_ready), .mem_reg(mem_reg), .acc_clr(acc_clr),
    .op_a(op_a32), .op_b(op_b32), .product(product32), .acc_out(acc_out32), .done(done32),
    .busy(busy32), .overflow(overflow32), .lost_word(lost_word32), .state(state32)
  );

  // behavioural model: phase 0 = waiting for A, 1 = waiting for B, 2 = computing,
  // m_cnt counts edges since B was captured
  int          m_phase = 0;
  int          m_cnt = 0;
  logic        m_drq = 1'b0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [31:0] m_prod = '0;
  logic [39:0] m_acc40 = '0;
  logic [31:0] m_acc32 = '0;
  logic        m_ovf40 = 1'b0, m_ovf32 = 1'b0, m_lost = 1'b0, m_done = 1'b0;
  logic        m_arr;
  logic [40:0] m_s40;
  logic [32:0] m_s32;

  always @(posedge clk) begin
    if (Reset) begin
      m_phase = 0; m_cnt = 0; m_drq = 1'b0; m_a = '0; m_b = '0; m_prod = '0;
      m_acc40 = '0; m_acc32 = '0; m_ovf40 = 1'b0; m_ovf32 = 1'b0; m_lost = 1'b0; m_done = 1'b0;
    end else begin
      m_arr  = data_ready && !m_drq;
      m_drq  = data_ready;
      m_done = 1'b0;
      if (acc_clr) begin
        m_acc40 = '0; m_acc32 = '0; m_prod = '0; m_ovf40 = 1'b0; m_ovf32 = 1'b0;
        m_lost = 1'b0; m_phase = 0;
      end else if (m_phase == 2) begin
        if (m_arr) m_lost = 1'b1;
        m_cnt++;
        if (m_cnt == 16) begin
          m_prod = 32'(m_a) * 32'(m_b);
        end else if (m_cnt == 17) begin
          m_s40 = 41'(m_acc40) + 41'(m_prod);
          m_s32 = 33'(m_acc32) + 33'(m_prod);
          m_acc40 = m_s40[39:0];
          m_acc32 = m_s32[31:0];
          if (m_s40[40]) m_ovf40 = 1'b1;
          if (m_s32[32]) m_ovf32 = 1'b1;
          m_done  = 1'b1;
          m_phase = 0;
        end
      end else if (m_arr) begin
        if (m_phase == 0) begin
          m_a = mem_reg; m_phase = 1;
        end else begin
          m_b = mem_reg; m_phase = 2; m_cnt = 0;
        end
      end
    end
  end

  function automatic logic [1:0] exp_state();
    if (m_phase == 2) return (m_cnt < 16) ? 2'd2 : 2'd3;
    return 2'(m_phase);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every output of both instances compared against the model each cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      check("op_a", 64'(op_a), 64'(m_a));
      check("op_b", 64'(op_b), 64'(m_b));
      check("product", 64'(product), 64'(m_prod));
      check("acc_out", 64'(acc_out), 64'(m_acc40));
      check("done", 64'(done), 64'(m_done));
      check("busy", 64'(busy), 64'(m_phase == 2));
      check("overflow", 64'(overflow), 64'(m_ovf40));
      check("lost_word", 64'(lost_word), 64'(m_lost));
      check("state", 64'(state), 64'(exp_state()));
      check("acc_out32", 64'(acc_out32), 64'(m_acc32));
      check("overflow32", 64'(overflow32), 64'(m_ovf32));
      check("done32", 64'(done32), 64'(m_done));
      check("product32", 64'(product32), 64'(m_prod));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    mem_reg = w;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();
  endtask

  task automatic pulse_clr();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
  endtask

  task automatic do_pair(input logic [15:0] a, input logic [15:0] b);
    send_word(a);
    send_word(b);
    repeat (18) tick();
  endtask

  int n;

  initial begin
    Reset = 1'b1; data_ready = 1'b0; mem_reg = '0; acc_clr = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    Reset = 1'b0;
    check("reset_state", 64'(state), 64'd0);
    check("reset_acc", 64'(acc_out), 64'd0);

    // 3 x 5, with end-to-end latency measured from the B-capture edge
    send_word(16'h0003);
    mem_reg = 16'h0005;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'd17);
    repeat (3) tick();
    check("s1_op_a", 64'(op_a), 64'h3);
    check("s1_op_b", 64'(op_b), 64'h5);
    check("s1_product", 64'(product), 64'hF);
    check("s1_acc", 64'(acc_out), 64'hF);

    do_pair(16'hFFFF, 16'hFFFF);
    check("s2_product", 64'(product), 64'hFFFE0001);
    check("s2_acc", 64'(acc_out), 64'h00FFFE0010);
    check("s2_ovf", 64'(overflow), 64'd0);

    // 32-bit accumulator wraps on the second 0xFFFF x 0xFFFF
    pulse_clr();
    do_pair(16'hFFFF, 16'hFFFF);
    check("s3_ovf32_first", 64'(overflow32), 64'd0);
    do_pair(16'hFFFF, 16'hFFFF);
    check("s3_acc32", 64'(acc_out32), 64'hFFFC0002);
    check("s3_ovf32", 64'(overflow32), 64'd1);
    check("s3_acc40", 64'(acc_out), 64'h1FFFC0002);

    // word arriving mid-multiply is dropped and flagged
    pulse_clr();
    send_word(16'h0007);
    send_word(16'h0009);
    repeat (3) tick();
    mem_reg = 16'hABCD;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    repeat (16) tick();
    check("s4_op_a", 64'(op_a), 64'h7);
    check("s4_op_b", 64'(op_b), 64'h9);
    check("s4_lost", 64'(lost_word), 64'd1);
    check("s4_acc", 64'(acc_out), 64'h3F);

    // held-high data_ready gives one arrival; clear mid-multiply aborts it
    pulse_clr();
    mem_reg = 16'h1234;
    data_ready = 1'b1;
    repeat (50) tick();
    check("s5_op_a", 64'(op_a), 64'h1234);
    check("s5_state", 64'(state), 64'd1);
    data_ready = 1'b0;
    tick();
    send_word(16'h0002);
    repeat (5) tick();
    pulse_clr();
    check("s5_clr_state", 64'(state), 64'd0);
    check("s5_clr_acc", 64'(acc_out), 64'd0);
    n = 0;
    repeat (20) begin
      tick();
      if (done) n++;
    end
    check("s5_no_done", 64'(n), 64'd0);

    // reset mid-multiply, then a fresh pair
    send_word(16'h0010);
    send_word(16'h0020);
    repeat (6) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("s6_op_a", 64'(op_a), 64'd0);
    check("s6_acc", 64'(acc_out), 64'd0);
    check("s6_state", 64'(state), 64'd0);
    repeat (20) tick();
    check("s6_no_done", 64'(done), 64'd0);
    do_pair(16'h0011, 16'h0013);
    check("s6_product", 64'(product), 64'h143);

    // data_ready already high when reset releases counts as an arrival
    Reset = 1'b1;
    mem_reg = 16'h0042;
    data_ready = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    check("s7_op_a", 64'(op_a), 64'h42);
    data_ready = 1'b0;
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 4) begin
        pulse_clr();
      end else if (sel < 6) begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
      end else if (sel < 10) begin
        mem_reg = 16'($urandom);
        data_ready = 1'b1;
        acc_clr = ($urandom_range(0, 1) == 1);
        repeat ($urandom_range(1, 6)) tick();
        acc_clr = 1'b0;
        data_ready = 1'b0;
      end else begin
        send_word(16'($urandom));
      end
      repeat ($urandom_range(0, 5)) tick();
    end
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
